// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler driving the select of a shared 16:1 mux, with a valid/ready
// handshake toward the consumer and a watchdog that revokes grants that are never accepted.
module mux16_rr_scheduler #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] req,
    input  logic        out_ready,
    output logic [3:0]  S,
    output logic [15:0] gnt,
    output logic        out_valid,
    output logic [15:0] ack,
    output logic        timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e             state_q;
    logic [3:0]         ptr_q;
    logic [CNT_W-1:0]   wdog_q;
    logic [3:0]         pick;
    logic [3:0]         idx;
    logic               wdog_expired;
    logic [3:0]         next_ptr;

    // Walk from the lowest-priority offset up so the closest set bit to ptr wins.
    always_comb begin
        pick = ptr_q;
        idx  = ptr_q;
        for (int i = 15; i >= 0; i--) begin
            idx = ptr_q + 4'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    assign wdog_expired = (wdog_q == CNT_W'(TIMEOUT - 1));
    assign next_ptr     = S + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            wdog_q    <= '0;
            S         <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            ack       <= '0;
            timeout   <= 1'b0;
        end else begin
            ack     <= '0;
            timeout <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (en && (req != '0)) begin
                        S         <= pick;
                        gnt       <= 16'd1 << pick;
                        out_valid <= 1'b1;
                        wdog_q    <= '0;
                        state_q   <= StGrant;
                    end
                end
                StGrant: begin
                    // Acceptance takes precedence over a watchdog expiring on the same cycle.
                    if (out_ready) begin
                        ack       <= gnt;
                        ptr_q     <= next_ptr;
                        out_valid <= 1'b0;
                        gnt       <= '0;
                        state_q   <= StIdle;
                    end else if (wdog_expired) begin
                        timeout   <= 1'b1;
                        ptr_q     <= next_ptr;
                        out_valid <= 1'b0;
                        gnt       <= '0;
                        state_q   <= StIdle;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    a_ack_timeout_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !((ack != '0) && timeout));
    a_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> (gnt == (16'd1 << S)));
    a_idle_no_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        !out_valid |-> (gnt == '0));

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Directed bench for mux16_rr_scheduler: a vector table for single-cycle behaviour plus
// hand-written sequences for wrap-around, watchdog expiry and the ready/expiry tie.
module tb_mux16_rr_scheduler;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] req;
    logic        out_ready;
    logic [3:0]  S;
    logic [15:0] gnt;
    logic        out_valid;
    logic [15:0] ack;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux16_rr_scheduler #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .out_ready (out_ready),
        .S         (S),
        .gnt       (gnt),
        .out_valid (out_valid),
        .ack       (ack),
        .timeout   (timeout)
    );

    typedef struct packed {
        logic        rst_n;
        logic        en;
        logic [15:0] req;
        logic        rdy;
        logic [3:0]  s;
        logic [15:0] gnt;
        logic        ov;
        logic [15:0] ack;
        logic        to;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic e, logic [15:0] rq, logic rd, logic [3:0] s,
                                logic [15:0] g, logic ov, logic [15:0] a, logic to);
        vec_t v;
        v = '{rst_n: r, en: e, req: rq, rdy: rd, s: s, gnt: g, ov: ov, ack: a, to: to};
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] s, input logic [15:0] g,
                             input logic ov, input logic [15:0] a, input logic to);
        check({tag, ".S"}, {12'd0, S}, {12'd0, s});
        check({tag, ".gnt"}, gnt, g);
        check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, ov});
        check({tag, ".ack"}, ack, a);
        check({tag, ".timeout"}, {15'd0, timeout}, {15'd0, to});
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; req = '0; out_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; req = '0; out_ready = 1'b0;

        //            rst en  req       rdy  S   gnt       ov  ack       to
        vq.push_back(mk(0, 0, 16'h0000, 0, 4'd0,  16'h0000, 0, 16'h0000, 0));
        vq.push_back(mk(1, 1, 16'h0001, 1, 4'd0,  16'h0001, 1, 16'h0000, 0));
        vq.push_back(mk(1, 1, 16'h0001, 1, 4'd0,  16'h0000, 0, 16'h0001, 0));
        vq.push_back(mk(1, 1, 16'h0002, 1, 4'd1,  16'h0002, 1, 16'h0000, 0));
        vq.push_back(mk(1, 1, 16'h0000, 1, 4'd1,  16'h0000, 0, 16'h0002, 0));
        vq.push_back(mk(1, 1, 16'h0010, 1, 4'd4,  16'h0010, 1, 16'h0000, 0));
        vq.push_back(mk(1, 1, 16'h0000, 1, 4'd4,  16'h0000, 0, 16'h0010, 0));
        // ptr=5: bit 4 only reachable after wrap, bit 0 comes first.
        vq.push_back(mk(1, 1, 16'h0011, 1, 4'd0,  16'h0001, 1, 16'h0000, 0));
        vq.push_back(mk(1, 1, 16'h0011, 1, 4'd0,  16'h0000, 0, 16'h0001, 0));
        vq.push_back(mk(1, 1, 16'h0011, 1, 4'd4,  16'h0010, 1, 16'h0000, 0));
        vq.push_back(mk(1, 1, 16'h0011, 1, 4'd4,  16'h0000, 0, 16'h0010, 0));
        vq.push_back(mk(1, 1, 16'h0030, 1, 4'd5,  16'h0020, 1, 16'h0000, 0));
        vq.push_back(mk(1, 1, 16'h0030, 1, 4'd5,  16'h0000, 0, 16'h0020, 0));
        vq.push_back(mk(1, 1, 16'h0030, 1, 4'd4,  16'h0010, 1, 16'h0000, 0));
        vq.push_back(mk(1, 1, 16'h0030, 1, 4'd4,  16'h0000, 0, 16'h0010, 0));
        // en=0 blocks new grants.
        vq.push_back(mk(1, 0, 16'hFFFF, 1, 4'd4,  16'h0000, 0, 16'h0000, 0));
        vq.push_back(mk(1, 0, 16'hFFFF, 1, 4'd4,  16'h0000, 0, 16'h0000, 0));
        // en=0 during a grant still lets it complete.
        vq.push_back(mk(1, 1, 16'hFFFF, 0, 4'd5,  16'h0020, 1, 16'h0000, 0));
        vq.push_back(mk(1, 0, 16'hFFFF, 0, 4'd5,  16'h0020, 1, 16'h0000, 0));
        vq.push_back(mk(1, 0, 16'hFFFF, 1, 4'd5,  16'h0000, 0, 16'h0020, 0));
        vq.push_back(mk(1, 0, 16'hFFFF, 1, 4'd5,  16'h0000, 0, 16'h0000, 0));
        // Reset mid-grant clears everything, including ptr.
        vq.push_back(mk(1, 1, 16'hFFFF, 0, 4'd6,  16'h0040, 1, 16'h0000, 0));
        vq.push_back(mk(0, 1, 16'hFFFF, 1, 4'd0,  16'h0000, 0, 16'h0000, 0));
        vq.push_back(mk(1, 1, 16'hFFFF, 0, 4'd0,  16'h0001, 1, 16'h0000, 0));
        vq.push_back(mk(1, 1, 16'hFFFF, 1, 4'd0,  16'h0000, 0, 16'h0001, 0));

        for (int i = 0; i < vq.size(); i++) begin
            rst_n = vq[i].rst_n; en = vq[i].en; req = vq[i].req; out_ready = vq[i].rdy;
            step();
            check_all($sformatf("vec%0d", i), vq[i].s, vq[i].gnt, vq[i].ov, vq[i].ack, vq[i].to);
        end

        // Full rotation with wrap 15 -> 0 and one idle cycle between grants.
        do_reset();
        en = 1'b1; req = 16'hFFFF; out_ready = 1'b1;
        for (int g = 0; g < 17; g++) begin
            step();
            check_all($sformatf("rot%0d_grant", g), 4'(g % 16), 16'd1 << (g % 16), 1'b1,
                      16'h0000, 1'b0);
            step();
            check_all($sformatf("rot%0d_idle", g), 4'(g % 16), 16'h0000, 1'b0,
                      16'd1 << (g % 16), 1'b0);
        end

        // Watchdog revokes grant of requester 3 after TIMEOUT cycles, ptr moves to 4.
        do_reset();
        en = 1'b1; req = 16'h0008; out_ready = 1'b0;
        step();
        check_all("wd_grant", 4'd3, 16'h0008, 1'b1, 16'h0000, 1'b0);
        req = 16'h0009;
        for (int c = 1; c < int'(TIMEOUT); c++) begin
            step();
            check_all($sformatf("wd_hold%0d", c), 4'd3, 16'h0008, 1'b1, 16'h0000, 1'b0);
        end
        step();
        check_all("wd_expire", 4'd3, 16'h0000, 1'b0, 16'h0000, 1'b1);
        step();
        check_all("wd_after", 4'd0, 16'h0001, 1'b1, 16'h0000, 1'b0);

        // Ready arriving on the expiry cycle wins over the watchdog.
        do_reset();
        en = 1'b1; req = 16'h0100; out_ready = 1'b0;
        step();
        check_all("tie_grant", 4'd8, 16'h0100, 1'b1, 16'h0000, 1'b0);
        for (int c = 1; c < int'(TIMEOUT); c++) begin
            step();
        end
        check_all("tie_last", 4'd8, 16'h0100, 1'b1, 16'h0000, 1'b0);
        out_ready = 1'b1;
        req = 16'h0000;
        step();
        check_all("tie_accept", 4'd8, 16'h0000, 1'b0, 16'h0100, 1'b0);
        step();
        check_all("tie_after", 4'd8, 16'h0000, 1'b0, 16'h0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
